// File: rtl/score_bcd_counter_pkg.sv
// Shared widths, limits, default point values and the judgement event type
// for the rhythm-game score/combo tracker.
package score_bcd_counter_pkg;

  localparam int BCD_W        = 4;
  localparam int SCORE_DIGITS = 4;
  localparam int COMBO_DIGITS = 2;

  localparam logic [SCORE_DIGITS*BCD_W-1:0] BCD_MAX_SCORE = 16'h9999;
  localparam logic [COMBO_DIGITS*BCD_W-1:0] BCD_MAX_COMBO = 8'h99;

  localparam int DEF_PERFECT_PTS    = 3;
  localparam int DEF_GOOD_PTS       = 1;
  localparam int DEF_COMBO_BONUS_AT = 10;

  typedef enum logic [1:0] {
    EV_NONE,
    EV_PERFECT,
    EV_GOOD,
    EV_MISS
  } event_t;

  // Converts a small constant (0..99) into two packed BCD digits.
  function automatic logic [7:0] to_bcd2(input int unsigned v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

endpackage

// File: rtl/score_bcd_counter_bcd_digit_add.sv
// Single decimal digit adder: a + b + cin with decimal carry out.
module bcd_digit_add
  import score_bcd_counter_pkg::*;
(
  input  logic [BCD_W-1:0] a,
  input  logic [BCD_W-1:0] b,
  input  logic             cin,
  output logic [BCD_W-1:0] sum,
  output logic             cout
);

  logic [BCD_W:0] raw;

  // Operands are legal BCD, so raw never exceeds 19 and one correction suffices.
  always_comb begin
    raw  = {1'b0, a} + {1'b0, b} + {{BCD_W{1'b0}}, cin};
    cout = (raw > (BCD_W+1)'(9));
    sum  = cout ? BCD_W'(raw - (BCD_W+1)'(10)) : raw[BCD_W-1:0];
  end

endmodule

// File: rtl/score_bcd_counter.sv
// Score and combo tracker: turns perfect/good/miss judgement pulses into a
// 4-digit BCD score, 2-digit BCD combo, sticky saturation flag and event strobe.
module score_bcd_counter
  import score_bcd_counter_pkg::*;
#(
  parameter int PERFECT_PTS    = DEF_PERFECT_PTS,
  parameter int GOOD_PTS       = DEF_GOOD_PTS,
  parameter int COMBO_BONUS_AT = DEF_COMBO_BONUS_AT
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          clear,
  input  logic                          enable,
  input  logic                          hit_perfect,
  input  logic                          hit_good,
  input  logic                          miss,
  output logic [SCORE_DIGITS*BCD_W-1:0] score_digits,
  output logic [COMBO_DIGITS*BCD_W-1:0] combo_digits,
  output logic                          score_sat,
  output logic                          event_valid
);

  localparam logic [7:0] PERFECT_BCD     = to_bcd2(PERFECT_PTS);
  localparam logic [7:0] PERFECT_DBL_BCD = to_bcd2(2 * PERFECT_PTS);
  localparam logic [7:0] GOOD_BCD        = to_bcd2(GOOD_PTS);
  localparam logic [7:0] GOOD_DBL_BCD    = to_bcd2(2 * GOOD_PTS);

  event_t                          ev;
  logic                            bonus;
  logic [6:0]                      combo_bin;
  logic [7:0]                      pts;
  logic [SCORE_DIGITS*BCD_W-1:0]   addend;
  logic [SCORE_DIGITS*BCD_W-1:0]   score_sum;
  logic [SCORE_DIGITS*BCD_W-1:0]   score_next;
  logic [SCORE_DIGITS:0]           s_carry;
  logic [COMBO_DIGITS*BCD_W-1:0]   combo_sum;
  logic [COMBO_DIGITS*BCD_W-1:0]   combo_next;
  logic [COMBO_DIGITS:0]           c_carry;

  // One event per cycle; clear and a low enable suppress every judgement.
  always_comb begin
    ev = EV_NONE;
    if (enable && !clear) begin
      if (hit_perfect)   ev = EV_PERFECT;
      else if (hit_good) ev = EV_GOOD;
      else if (miss)     ev = EV_MISS;
    end
  end

  always_comb begin
    combo_bin = {3'b000, combo_digits[7:4]} * 7'd10 + {3'b000, combo_digits[3:0]};
    bonus     = (combo_bin >= 7'(COMBO_BONUS_AT));
    pts       = 8'h00;
    case (ev)
      EV_PERFECT: pts = bonus ? PERFECT_DBL_BCD : PERFECT_BCD;
      EV_GOOD:    pts = bonus ? GOOD_DBL_BCD : GOOD_BCD;
      default:    pts = 8'h00;
    endcase
    addend = {{(SCORE_DIGITS*BCD_W-8){1'b0}}, pts};
  end

  assign s_carry[0] = 1'b0;
  assign c_carry[0] = 1'b1;

  for (genvar i = 0; i < SCORE_DIGITS; i++) begin : g_score
    bcd_digit_add u_add (
      .a    (score_digits[i*BCD_W +: BCD_W]),
      .b    (addend[i*BCD_W +: BCD_W]),
      .cin  (s_carry[i]),
      .sum  (score_sum[i*BCD_W +: BCD_W]),
      .cout (s_carry[i+1])
    );
  end

  // Combo increment rides the same digit adder with a zero addend and carry-in.
  for (genvar i = 0; i < COMBO_DIGITS; i++) begin : g_combo
    bcd_digit_add u_inc (
      .a    (combo_digits[i*BCD_W +: BCD_W]),
      .b    ({BCD_W{1'b0}}),
      .cin  (c_carry[i]),
      .sum  (combo_sum[i*BCD_W +: BCD_W]),
      .cout (c_carry[i+1])
    );
  end

  assign score_next = s_carry[SCORE_DIGITS] ? BCD_MAX_SCORE : score_sum;
  assign combo_next = c_carry[COMBO_DIGITS] ? BCD_MAX_COMBO : combo_sum;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      score_digits <= '0;
      combo_digits <= '0;
      score_sat    <= 1'b0;
      event_valid  <= 1'b0;
    end else if (clear) begin
      score_digits <= '0;
      combo_digits <= '0;
      score_sat    <= 1'b0;
      event_valid  <= 1'b0;
    end else begin
      event_valid <= (ev != EV_NONE);
      case (ev)
        EV_PERFECT, EV_GOOD: begin
          score_digits <= score_next;
          combo_digits <= combo_next;
          if (s_carry[SCORE_DIGITS]) score_sat <= 1'b1;
        end
        EV_MISS: combo_digits <= '0;
        default: ;
      endcase
    end
  end

endmodule
